// File: rtl/soc_system_data_nios2arm_out_pkg.sv
// Shared constants for the Nios->ARM output port: sizes, register map,
// status/control bit positions and the status word builder.
package soc_system_data_nios2arm_out_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // Status register bit positions
  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;

  // Control register bit positions
  localparam int CTRL_IRQ_EN_BIT  = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int CTRL_CLR_OVF_BIT = 2;

  // Assemble the status word; unused bits read as zero.
  function automatic logic [DATA_W-1:0] build_status(
    input logic [CNT_W-1:0] cnt,
    input logic             empty,
    input logic             full,
    input logic             ovf
  );
    logic [DATA_W-1:0] s;
    s                 = {DATA_W{1'b0}};
    s[CNT_W-1:0]      = cnt;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_FULL_BIT]  = full;
    s[STAT_OVF_BIT]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/soc_system_data_nios2arm_out_if.sv
// Avalon-MM slave bus plus the ARM-side stream handshake and interrupt.
interface soc_system_data_nios2arm_out_if;
  import soc_system_data_nios2arm_out_pkg::*;

  logic [1:0]        address;
  logic              write_n;
  logic              chipselect;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ack;
  logic              irq;

  modport slave (
    input  address, write_n, chipselect, writedata, out_ack,
    output readdata, out_data, out_valid, irq
  );

  modport master (
    output address, write_n, chipselect, writedata, out_ack,
    input  readdata, out_data, out_valid, irq
  );

endinterface

// File: rtl/soc_system_data_nios2arm_fifo.sv
// Show-ahead FIFO: head word is visible while non-empty and zero otherwise.
// Flush clears pointers/count and overrides any same-cycle push or pop.
module soc_system_data_nios2arm_fifo
  import soc_system_data_nios2arm_out_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int DP = DEPTH,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_push_acc
);

  localparam int AW = $clog2(DP);

  logic [DW-1:0] r_mem [DP];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pop_acc;
  logic          w_push_acc;

  assign w_empty    = (r_count == {CW{1'b0}});
  assign w_full     = (r_count == CW'(DP));
  // A pop frees a slot in the same cycle, so a push into a full FIFO is taken then.
  assign w_pop_acc  = i_pop & ~w_empty & ~i_flush;
  assign w_push_acc = i_push & (~w_full | w_pop_acc) & ~i_flush;

  assign o_head     = w_empty ? {DW{1'b0}} : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_push_acc = w_push_acc;

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/soc_system_data_nios2arm_out.sv
// Nios II -> ARM output port: Avalon-MM slave decode, status/control
// registers, registered read mux and empty interrupt around the FIFO.
module soc_system_data_nios2arm_out
  import soc_system_data_nios2arm_out_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  soc_system_data_nios2arm_out_if.slave  bus
);

  logic              w_wr;
  logic              w_push;
  logic              w_ctrl_wr;
  logic              w_flush;
  logic              w_clr_ovf;
  logic              w_push_acc;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_rd_mux;

  logic              r_irq_en;
  logic              r_overflow;
  logic [DATA_W-1:0] r_last;
  logic [DATA_W-1:0] r_readdata;

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_push    = w_wr & (bus.address == ADDR_DATA);
  assign w_ctrl_wr = w_wr & (bus.address == ADDR_CTRL);
  assign w_flush   = w_ctrl_wr & bus.writedata[CTRL_FLUSH_BIT];
  assign w_clr_ovf = w_ctrl_wr & bus.writedata[CTRL_CLR_OVF_BIT];

  soc_system_data_nios2arm_fifo #(
    .DW (DATA_W),
    .DP (DEPTH),
    .CW (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_pop      (bus.out_ack),
    .i_flush    (w_flush),
    .i_wdata    (bus.writedata),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_push_acc (w_push_acc)
  );

  // Control and sticky status; a push refused for lack of space flags overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en   <= 1'b0;
      r_overflow <= 1'b0;
      r_last     <= {DATA_W{1'b0}};
    end else begin
      if (w_ctrl_wr) r_irq_en <= bus.writedata[CTRL_IRQ_EN_BIT];
      if (w_clr_ovf) begin
        r_overflow <= 1'b0;
      end else if (w_push && !w_push_acc) begin
        r_overflow <= 1'b1;
      end
      if (w_flush) begin
        r_last <= {DATA_W{1'b0}};
      end else if (w_push_acc) begin
        r_last <= bus.writedata;
      end
    end
  end

  // Register read selection; reads have no side effects.
  always_comb begin
    w_rd_mux = {DATA_W{1'b0}};
    case (bus.address)
      ADDR_DATA:   w_rd_mux = r_last;
      ADDR_STATUS: w_rd_mux = build_status(w_count, w_empty, w_full, r_overflow);
      ADDR_CTRL:   w_rd_mux = {{(DATA_W-1){1'b0}}, r_irq_en};
      ADDR_RSVD:   w_rd_mux = {DATA_W{1'b0}};
      default:     w_rd_mux = {DATA_W{1'b0}};
    endcase
  end

  // Read data register: one-cycle latency, zero when not selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= {DATA_W{1'b0}};
    end else if (bus.chipselect) begin
      r_readdata <= w_rd_mux;
    end else begin
      r_readdata <= {DATA_W{1'b0}};
    end
  end

  assign bus.readdata  = r_readdata;
  assign bus.out_data  = w_head;
  assign bus.out_valid = ~w_empty;
  assign bus.irq       = r_irq_en & w_empty;

endmodule
